// File: rtl/seq_signed_div.sv
// seq_signed_div
//   Sequential signed divider. It divides a 2*width-bit signed dividend M by a
//   width-bit signed divisor B with unsigned restoring division, producing one
//   quotient bit per cycle, and then applies the signs. The quotient truncates
//   toward zero and the remainder takes the sign of the dividend.
//   The handshake matches the sequential Booth multiplier: en starts a run in
//   IDLE, and done pulses for one cycle when the result registers update.
// Ports
//   clk   : rising-edge clock
//   rst   : asynchronous active-high reset
//   en    : start request, level-sampled in IDLE only
//   M     : signed dividend (2*width bits)
//   B     : signed divisor (width bits)
//   busy  : high from the start edge until done falls
//   done  : one-cycle result-valid pulse
//   Q, R  : signed quotient / remainder, held until the next result
//   ovf   : quotient out of signed width-bit range (Q saturated, R=0)
//   div0  : divisor was zero (Q=-1, R=0)
module seq_signed_div #(
  parameter int width = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic signed [2*width-1:0] M,
  input  logic signed [width-1:0]   B,
  output logic                      busy,
  output logic                      done,
  output logic signed [width-1:0]   Q,
  output logic signed [width-1:0]   R,
  output logic                      ovf,
  output logic                      div0
);

  localparam int DW = 2 * width;
  localparam int CW = $clog2(DW) + 1;
  localparam logic [CW-1:0]    LAST_ITER = CW'(DW - 1);
  // Largest quotient magnitudes that still fit: 2^(width-1) when negative,
  // 2^(width-1)-1 when positive.
  localparam logic [DW-1:0]    NEG_LIM   = DW'(1) << (width - 1);
  localparam logic [DW-1:0]    POS_LIM   = (DW'(1) << (width - 1)) - DW'(1);
  localparam logic [width-1:0] Q_MIN     = {1'b1, {(width-1){1'b0}}};
  localparam logic [width-1:0] Q_MAX     = {1'b0, {(width-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  // Two's-complement magnitude read as unsigned. The most-negative value maps
  // to 2^(n-1), which is exact in n unsigned bits, so nothing wraps.
  function automatic logic [DW-1:0] mag_dividend(input logic [DW-1:0] v);
    return v[DW-1] ? (~v + DW'(1)) : v;
  endfunction

  function automatic logic [width-1:0] mag_divisor(input logic [width-1:0] v);
    return v[width-1] ? (~v + width'(1)) : v;
  endfunction

  state_t           state_r;
  logic [CW-1:0]    cnt_r;
  logic [DW-1:0]    quo_r;     // |M| shifting out on top, quotient bits in at bottom
  logic [width-1:0] rem_r;     // partial remainder, always < |B| for B != 0
  logic [width-1:0] babs_r;
  logic             m_sign_r;
  logic             b_sign_r;

  logic [width:0]   rem_sh_s;
  logic [width:0]   diff_s;
  logic             ge_s;
  logic [width-1:0] rem_nxt_s;
  logic [DW-1:0]    quo_nxt_s;
  logic             neg_q_s;
  logic             ovf_lim_s;
  logic [width-1:0] q_fix_s;
  logic [width-1:0] r_fix_s;
  logic             ovf_fix_s;
  logic             div0_fix_s;

  // One restoring-division step: the borrow out of rem_sh - |B| decides the
  // quotient bit. rem_sh < 2^width whenever B != 0, so the borrow is exact.
  always_comb begin
    rem_sh_s  = {rem_r, quo_r[DW-1]};
    diff_s    = rem_sh_s - {1'b0, babs_r};
    ge_s      = ~diff_s[width];
    rem_nxt_s = ge_s ? diff_s[width-1:0] : rem_sh_s[width-1:0];
    quo_nxt_s = {quo_r[DW-2:0], ge_s};
  end

  // Sign application, saturation on overflow and the divide-by-zero override.
  always_comb begin
    neg_q_s    = m_sign_r ^ b_sign_r;
    ovf_lim_s  = neg_q_s ? (quo_r > NEG_LIM) : (quo_r > POS_LIM);
    q_fix_s    = '0;
    r_fix_s    = '0;
    ovf_fix_s  = 1'b0;
    div0_fix_s = 1'b0;
    if (babs_r == '0) begin
      div0_fix_s = 1'b1;
      q_fix_s    = '1;
    end else if (ovf_lim_s) begin
      ovf_fix_s  = 1'b1;
      q_fix_s    = neg_q_s ? Q_MIN : Q_MAX;
    end else begin
      q_fix_s    = neg_q_s ? (~quo_r[width-1:0] + width'(1)) : quo_r[width-1:0];
      r_fix_s    = m_sign_r ? (~rem_r + width'(1)) : rem_r;
    end
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      cnt_r    <= '0;
      quo_r    <= '0;
      rem_r    <= '0;
      babs_r   <= '0;
      m_sign_r <= 1'b0;
      b_sign_r <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      Q        <= '0;
      R        <= '0;
      ovf      <= 1'b0;
      div0     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (en) begin
            m_sign_r <= M[DW-1];
            b_sign_r <= B[width-1];
            quo_r    <= mag_dividend(M);
            babs_r   <= mag_divisor(B);
            rem_r    <= '0;
            cnt_r    <= '0;
            busy     <= 1'b1;
            state_r  <= CALC;
          end else begin
            state_r  <= IDLE;
          end
        end
        CALC: begin
          rem_r <= rem_nxt_s;
          quo_r <= quo_nxt_s;
          cnt_r <= cnt_r + CW'(1);
          if (cnt_r == LAST_ITER) begin
            state_r <= FIX;
          end else begin
            state_r <= CALC;
          end
        end
        FIX: begin
          Q       <= q_fix_s;
          R       <= r_fix_s;
          ovf     <= ovf_fix_s;
          div0    <= div0_fix_s;
          done    <= 1'b1;
          state_r <= DONE;
        end
        DONE: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done    <= 1'b0;
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_signed_div.sv
// tb_seq_signed_div
//   Directed-vector bench for seq_signed_div (width=8). Expected quotients,
//   remainders and flags are hand-computed constants, apart from the inverse
//   sweep where the dividend is built as A*B and the expected quotient is A.
module tb_seq_signed_div;

  logic               clk;
  logic               rst;
  logic               en;
  logic signed [15:0] M;
  logic signed [7:0]  B;
  logic               busy;
  logic               done;
  logic signed [7:0]  Q;
  logic signed [7:0]  R;
  logic               ovf;
  logic               div0;

  int n_vec  = 0;
  int n_miss = 0;

  seq_signed_div #(.width(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .M    (M),
    .B    (B),
    .busy (busy),
    .done (done),
    .Q    (Q),
    .R    (R),
    .ovf  (ovf),
    .div0 (div0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Drive operands with en=1 and step past the start edge.
  task automatic start_op(input logic signed [15:0] m, input logic signed [7:0] b);
    M  = m;
    B  = b;
    en = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Count edges after the start edge until done is seen; -1 if never.
  // With perturb set, en/M/B are scrambled during the first edges of CALC.
  task automatic wait_done(output int lat, input bit perturb);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (done) begin
        lat = n;
        break;
      end
      if (perturb && n <= 15) begin
        en = n[0];
        M  = 16'($urandom);
        B  = 8'($urandom);
      end
    end
  endtask

  task automatic do_div(input string tag, input logic signed [15:0] m,
                        input logic signed [7:0] b, input int q_exp, input int r_exp,
                        input int ovf_exp, input int div0_exp, input bit perturb);
    int lat;
    start_op(m, b);
    chk($sformatf("%s.busy_rise", tag), busy, 1);
    wait_done(lat, perturb);
    chk($sformatf("%s.latency", tag), lat, 17);
    chk($sformatf("%s.Q", tag), Q, q_exp);
    chk($sformatf("%s.R", tag), R, r_exp);
    chk($sformatf("%s.ovf", tag), ovf, ovf_exp);
    chk($sformatf("%s.div0", tag), div0, div0_exp);
    @(posedge clk);
    #1;
    en = 1'b0;
    chk($sformatf("%s.done_fall", tag), done, 0);
    chk($sformatf("%s.busy_fall", tag), busy, 0);
  endtask

  int avals[11] = '{-128, -127, -100, -64, -1, 0, 1, 2, 63, 100, 127};
  int bvals[8]  = '{-128, -127, -3, -1, 1, 2, 7, 127};

  initial begin
    int lat1;
    int lat2;
    int seen;
    rst = 1'b1;
    en  = 1'b0;
    M   = '0;
    B   = '0;
    #1;
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.Q", Q, 0);
    chk("rst.R", R, 0);
    chk("rst.ovf", ovf, 0);
    chk("rst.div0", div0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    do_div("basic", 16'sd1000, -8'sd100, -10, 0, 0, 0, 1'b0);

    do_div("trunc_m7_2", -16'sd7, 8'sd2, -3, -1, 0, 0, 1'b0);
    do_div("trunc_7_m2", 16'sd7, -8'sd2, -3, 1, 0, 0, 1'b0);
    do_div("trunc_m7_m2", -16'sd7, -8'sd2, 3, -1, 0, 0, 1'b0);
    do_div("trunc_6_7", 16'sd6, 8'sd7, 0, 6, 0, 0, 1'b0);

    do_div("ovf_16384_m1", 16'sd16384, -8'sd1, -128, 0, 1, 0, 1'b0);
    do_div("ovf_m32768_1", -16'sd32768, 8'sd1, -128, 0, 1, 0, 1'b0);
    do_div("ovf_32767_1", 16'sd32767, 8'sd1, 127, 0, 1, 0, 1'b0);
    do_div("div0_1234", 16'sd1234, 8'sd0, -1, 0, 0, 1, 1'b0);
    do_div("inv_m128_m1", 16'sd128, -8'sd1, -128, 0, 0, 0, 1'b0);

    foreach (avals[i]) begin
      foreach (bvals[j]) begin
        do_div($sformatf("inv_a%0d_b%0d", avals[i], bvals[j]),
               16'(avals[i] * bvals[j]), 8'(bvals[j]), avals[i], 0, 0, 0, 1'b0);
      end
    end

    // Operand and en changes during CALC must not leak into the result.
    do_div("perturb", -16'sd7, 8'sd2, -3, -1, 0, 0, 1'b1);

    // en held through done: back-to-back restart, dones 19 edges apart.
    start_op(16'sd1000, -8'sd100);
    wait_done(lat1, 1'b0);
    chk("hold.lat1", lat1, 17);
    chk("hold.Q1", Q, -10);
    M = 16'sd21;
    B = -8'sd3;
    wait_done(lat2, 1'b0);
    en = 1'b0;
    chk("hold.spacing", lat2, 19);
    chk("hold.Q2", Q, -7);
    chk("hold.R2", R, 0);
    @(posedge clk);
    #1;

    // Reset five cycles into an operation aborts it and clears the outputs.
    start_op(16'sd1000, -8'sd100);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    en  = 1'b0;
    #1;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.Q", Q, 0);
    chk("abort.R", R, 0);
    chk("abort.ovf", ovf, 0);
    chk("abort.div0", div0, 0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 0;
    for (int n = 0; n < 25; n++) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("abort.no_done", seen, 0);
    chk("abort.Q_held", Q, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/seq_signed_div.md
# seq_signed_div

Sequential signed divider: the inverse of the team's sequential Booth multiplier. It takes a 2*width-bit signed dividend, for example a multiplier product M, and a width-bit signed divisor B. It returns a truncating quotient Q and remainder R after a fixed number of cycles, using the same en/done handshake as the multiplier. Its intended uses are recovering one factor from a product and serving as a self-check partner in multiplier benches.

## Interface
- width, 8: divisor, quotient and remainder width; dividend is 2*width.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  start request; level-sampled in IDLE.
- M  in  2*width  signed dividend.
- B  in  width  signed divisor.
- busy  out  1  high from the start edge until done falls.
- done  out  1  one-cycle result-valid pulse.
- Q  out  width  signed quotient.
- R  out  width  signed remainder.
- ovf  out  1  quotient out of range; valid with done.
- div0  out  1  divisor was zero; valid with done.

## Operation
- States are IDLE, CALC, FIX and DONE.
- IDLE:
  - On en=1, latch M and B and their signs.
  - Load |M| (2*width bits, unsigned) and |B| (width bits, unsigned); clear the iteration counter; go to CALC.
- CALC: unsigned restoring division, one quotient bit per cycle.
  - Shift {rem,quo} left by 1.
  - Subtract |B| from rem when rem ≥ |B| and set the quotient LSB.
  - Run exactly 2*width iterations, then go to FIX.
- FIX:
  - Apply signs. The quotient is negative iff sign(M) differs from sign(B). The remainder takes the sign of M.
  - Register Q, R, ovf and div0; go to DONE.
- DONE: done=1 for one cycle; then go to IDLE unconditionally.
- Arithmetic rules:
  - Division truncates toward zero: M = Q*B + R, |R| < |B|.
  - |R| ≤ 2^(width-1)-1, so R always fits.
  - ovf=1 when the true quotient lies outside [-2^(width-1), 2^(width-1)-1]. Q then saturates to the nearer bound, R=0.
  - div0=1 when B=0. Q = all ones (-1), R=0, ovf=0.
  - |M| of the most-negative dividend (-2^(2*width-1)) must be handled without wrap; the magnitude register is 2*width+1 bits or equivalent.
- Q, R, ovf and div0 hold their values from DONE until the next FIX; they are not cleared on start.
- en, M and B are ignored outside IDLE. Operand changes mid-operation do not affect the result.

## Timing
- Reset values: busy=0, done=0, Q=0, R=0, ovf=0, div0=0, state IDLE.
- Reset asserted mid-operation aborts immediately; no done pulse follows release.
- Start edge is the edge at which IDLE samples en=1; busy rises after it.
- Done timing:
  - done is high for the cycle following edge start+2*width+1. For width=8, done rises 17 edges after the start edge.
  - Q, R, ovf and div0 change at that same edge.
- busy falls at the edge where done falls.
- Minimum start-to-start spacing is 2*width+3 edges.
- If en is still high when the block returns to IDLE, it restarts on the next edge with newly sampled operands.
- Intended master behaviour: clear en at the edge where it samples done=1. IDLE then sees en=0.

## Test plan
- Reset:
  - Assert rst 5 cycles after a start.
  - Required: all outputs 0 at once; no done pulse after release; IDLE with en=0 stays idle.
- Basic:
  - Stimulus: M=1000, B=-100, en held until done.
  - Required: Q=-10, R=0, ovf=0, div0=0; done high exactly 17 edges after start, for one cycle.
- Truncation signs:
  - (M=-7, B=2) → Q=-3, R=-1.
  - (7, -2) → Q=-3, R=1.
  - (-7, -2) → Q=3, R=-1.
  - (6, 7) → Q=0, R=6.
- Exhaustive inverse:
  - For every A, B in [-128, 127] with B≠0, apply M=A*B.
  - Required: Q=A, R=0, ovf=0. This includes A=-128 with B=-1 (M=128).
- Edge cases:
  - (M=16384, B=-1) → ovf=1, Q=-128.
  - (M=-32768, B=1) → ovf=1, Q=-128.
  - (M=32767, B=1) → ovf=1, Q=127.
  - (M=1234, B=0) → div0=1, Q=-1, R=0.
- Handshake:
  - Toggle en and change M/B during CALC → result unchanged.
  - Hold en high through done → second operation starts on the first IDLE edge; second done 19 edges after the first.
